// File: rtl/wb_stage.sv
// -----------------------------------------------------------------------------
// wb_stage -- writeback stage of the ares RISC-V core.
//
// Takes completed instructions from execute and drives the register-file write
// port. ALU and PC+4 results are written one cycle after acceptance. Loads park
// the stage in WAIT_MEM until data memory answers. The answer is then aligned,
// sign- or zero-extended and written, or reported as a fault on err_o. A load
// that is never answered is abandoned after TIMEOUT cycles.
//
// Ports
//   clk_i, rst_i          clock (rising edge), asynchronous active-low reset
//   ex_valid_i/ex_ready_o instruction handshake with execute (ready only in IDLE)
//   ex_regwen_i, ex_rd_i  write enable and destination register
//   ex_wbsel_i            0 ALU, 1 MEM, 2 PC+4, 3 reserved (no write)
//   ex_alu_i, ex_pc4_i    result candidates
//   ex_funct3_i           load type
//   ex_addr_lo_i          load address bits [1:0]
//   mem_rvalid_i          load response strobe
//   mem_rdata_i           load response word
//   mem_err_i             bus error, qualified by mem_rvalid_i
//   RegWEn_o/AddrD_o/DataD_o  registered register-file write port
//   load_busy_o, load_rd_o    outstanding-load indication for the hazard unit
//   err_o                 one-cycle load fault pulse
// -----------------------------------------------------------------------------
module wb_stage #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        ex_valid_i,
  output logic        ex_ready_o,
  input  logic        ex_regwen_i,
  input  logic [4:0]  ex_rd_i,
  input  logic [1:0]  ex_wbsel_i,
  input  logic [31:0] ex_alu_i,
  input  logic [31:0] ex_pc4_i,
  input  logic [2:0]  ex_funct3_i,
  input  logic [1:0]  ex_addr_lo_i,
  input  logic        mem_rvalid_i,
  input  logic [31:0] mem_rdata_i,
  input  logic        mem_err_i,
  output logic        RegWEn_o,
  output logic [4:0]  AddrD_o,
  output logic [31:0] DataD_o,
  output logic        load_busy_o,
  output logic [4:0]  load_rd_o,
  output logic        err_o
);

  typedef enum logic [0:0] {IDLE, WAIT_MEM} state_t;

  // The counter starts at 0 on entry, so the final WAIT_MEM cycle is the one
  // in which it reads TIMEOUT-1.
  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [4:0]  ld_rd_q, ld_rd_d;
  logic        ld_wen_q, ld_wen_d;
  logic [2:0]  ld_f3_q, ld_f3_d;
  logic [1:0]  ld_alo_q, ld_alo_d;
  logic        regwen_q, regwen_d;
  logic [4:0]  addr_q, addr_d;
  logic [31:0] data_q, data_d;
  logic        err_q, err_d;

  // Only LB/LH/LW/LBU/LHU exist. Halfwords must sit on an even address and
  // words on a word boundary.
  function automatic logic load_legal(input logic [2:0] f3, input logic [1:0] alo);
    logic ok;
    case (f3)
      3'b000, 3'b100: ok = 1'b1;
      3'b001, 3'b101: ok = ~alo[0];
      3'b010:         ok = (alo == 2'd0);
      default:        ok = 1'b0;
    endcase
    return ok;
  endfunction

  // Shift the addressed byte or halfword down to bit 0, then extend it.
  function automatic logic [31:0] load_align(input logic [2:0]  f3,
                                             input logic [1:0]  alo,
                                             input logic [31:0] rdata);
    logic [31:0] sh;
    logic [31:0] res;
    sh = rdata >> {alo, 3'b000};
    case (f3)
      3'b000:  res = {{24{sh[7]}}, sh[7:0]};
      3'b100:  res = {24'd0, sh[7:0]};
      3'b001:  res = {{16{sh[15]}}, sh[15:0]};
      3'b101:  res = {16'd0, sh[15:0]};
      default: res = rdata;
    endcase
    return res;
  endfunction

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    ld_rd_d  = ld_rd_q;
    ld_wen_d = ld_wen_q;
    ld_f3_d  = ld_f3_q;
    ld_alo_d = ld_alo_q;
    regwen_d = 1'b0;
    err_d    = 1'b0;
    addr_d   = addr_q;
    data_d   = data_q;

    case (state_q)
      IDLE: begin
        // mem_rvalid_i is deliberately ignored here: it can only be a stray
        // or late response to a load that has already been abandoned.
        if (ex_valid_i) begin
          case (ex_wbsel_i)
            2'd0: begin
              regwen_d = ex_regwen_i && (ex_rd_i != 5'd0);
              addr_d   = ex_rd_i;
              data_d   = ex_alu_i;
            end
            2'd2: begin
              regwen_d = ex_regwen_i && (ex_rd_i != 5'd0);
              addr_d   = ex_rd_i;
              data_d   = ex_pc4_i;
            end
            2'd1: begin
              ld_rd_d  = ex_rd_i;
              ld_wen_d = ex_regwen_i;
              ld_f3_d  = ex_funct3_i;
              ld_alo_d = ex_addr_lo_i;
              cnt_d    = 8'd0;
              state_d  = WAIT_MEM;
            end
            default: ;  // reserved source: consumed without a write
          endcase
        end
      end

      WAIT_MEM: begin
        // A response arriving in the final cycle still takes priority over
        // the timeout.
        if (mem_rvalid_i) begin
          state_d = IDLE;
          if (!mem_err_i && load_legal(ld_f3_q, ld_alo_q)) begin
            regwen_d = ld_wen_q && (ld_rd_q != 5'd0);
            addr_d   = ld_rd_q;
            data_d   = load_align(ld_f3_q, ld_alo_q, mem_rdata_i);
          end else begin
            err_d = 1'b1;
          end
        end else if (cnt_q == TMO_LAST) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q  <= IDLE;
      cnt_q    <= 8'd0;
      ld_rd_q  <= 5'd0;
      ld_wen_q <= 1'b0;
      ld_f3_q  <= 3'd0;
      ld_alo_q <= 2'd0;
      regwen_q <= 1'b0;
      addr_q   <= 5'd0;
      data_q   <= 32'd0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      ld_rd_q  <= ld_rd_d;
      ld_wen_q <= ld_wen_d;
      ld_f3_q  <= ld_f3_d;
      ld_alo_q <= ld_alo_d;
      regwen_q <= regwen_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
      err_q    <= err_d;
    end
  end

  assign ex_ready_o  = (state_q == IDLE);
  assign load_busy_o = (state_q == WAIT_MEM);
  assign load_rd_o   = (state_q == WAIT_MEM) ? ld_rd_q : 5'd0;
  assign RegWEn_o    = regwen_q;
  assign AddrD_o     = addr_q;
  assign DataD_o     = data_q;
  assign err_o       = err_q;

endmodule

// File: tb/tb_wb_stage.sv
// -----------------------------------------------------------------------------
// tb_wb_stage -- scoreboard bench for wb_stage (TIMEOUT = 4).
// The stimulus process pushes expected write/fault events and expected
// handshake status. A monitor on the falling edge pops and compares them.
// -----------------------------------------------------------------------------
module tb_wb_stage;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        ex_valid_i;
  logic        ex_ready_o;
  logic        ex_regwen_i;
  logic [4:0]  ex_rd_i;
  logic [1:0]  ex_wbsel_i;
  logic [31:0] ex_alu_i;
  logic [31:0] ex_pc4_i;
  logic [2:0]  ex_funct3_i;
  logic [1:0]  ex_addr_lo_i;
  logic        mem_rvalid_i;
  logic [31:0] mem_rdata_i;
  logic        mem_err_i;
  logic        RegWEn_o;
  logic [4:0]  AddrD_o;
  logic [31:0] DataD_o;
  logic        load_busy_o;
  logic [4:0]  load_rd_o;
  logic        err_o;

  always #5 clk_i = ~clk_i;

  wb_stage #(.TIMEOUT(4)) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .ex_valid_i   (ex_valid_i),
    .ex_ready_o   (ex_ready_o),
    .ex_regwen_i  (ex_regwen_i),
    .ex_rd_i      (ex_rd_i),
    .ex_wbsel_i   (ex_wbsel_i),
    .ex_alu_i     (ex_alu_i),
    .ex_pc4_i     (ex_pc4_i),
    .ex_funct3_i  (ex_funct3_i),
    .ex_addr_lo_i (ex_addr_lo_i),
    .mem_rvalid_i (mem_rvalid_i),
    .mem_rdata_i  (mem_rdata_i),
    .mem_err_i    (mem_err_i),
    .RegWEn_o     (RegWEn_o),
    .AddrD_o      (AddrD_o),
    .DataD_o      (DataD_o),
    .load_busy_o  (load_busy_o),
    .load_rd_o    (load_rd_o),
    .err_o        (err_o)
  );

  typedef struct {
    bit          is_err;
    logic [4:0]  addr;
    logic [31:0] data;
    string       nm;
  } ev_t;

  typedef struct {
    bit         rdy;
    bit         busy;
    logic [4:0] lrd;
    bit         zero;
    string      nm;
  } st_t;

  ev_t evq[$];
  st_t stq[$];
  int  n_cmp = 0;
  int  n_bad = 0;
  bit  done  = 1'b0;

  ev_t mon_e;
  st_t mon_s;
  bit  mon_ok;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic push_wr(input string nm, input logic [4:0] a, input logic [31:0] d);
    ev_t e;
    e.is_err = 1'b0; e.addr = a; e.data = d; e.nm = nm;
    evq.push_back(e);
  endtask

  task automatic push_err(input string nm);
    ev_t e;
    e.is_err = 1'b1; e.addr = 5'd0; e.data = 32'd0; e.nm = nm;
    evq.push_back(e);
  endtask

  task automatic push_st(input string nm, input bit rdy, input bit busy,
                         input logic [4:0] lrd, input bit zero);
    st_t s;
    s.rdy = rdy; s.busy = busy; s.lrd = lrd; s.zero = zero; s.nm = nm;
    stq.push_back(s);
  endtask

  // One-cycle non-load instruction.
  task automatic issue(input bit wen, input logic [4:0] rd, input logic [1:0] sel,
                       input logic [31:0] alu, input logic [31:0] pc4);
    ex_valid_i = 1'b1; ex_regwen_i = wen; ex_rd_i = rd; ex_wbsel_i = sel;
    ex_alu_i = alu; ex_pc4_i = pc4;
    tick();
    ex_valid_i = 1'b0;
  endtask

  // Accept a load, wait nwait cycles in WAIT_MEM; when rsp is set, the
  // response is presented in the last of those cycles.
  task automatic do_load(input logic [4:0] rd, input bit wen, input logic [2:0] f3,
                         input logic [1:0] alo, input int nwait, input bit rsp,
                         input logic [31:0] rdata, input bit merr);
    ex_valid_i = 1'b1; ex_regwen_i = wen; ex_rd_i = rd; ex_wbsel_i = 2'd1;
    ex_funct3_i = f3; ex_addr_lo_i = alo;
    tick();
    ex_valid_i = 1'b0;
    for (int i = 0; i < nwait; i++) begin
      push_st("load_wait", 1'b0, 1'b1, rd, 1'b0);
      if (rsp && i == nwait - 1) begin
        mem_rvalid_i = 1'b1; mem_rdata_i = rdata; mem_err_i = merr;
      end
      tick();
    end
    mem_rvalid_i = 1'b0; mem_err_i = 1'b0;
    push_st("load_done", 1'b1, 1'b0, 5'd0, 1'b0);
  endtask

  always @(negedge clk_i) begin
    if (RegWEn_o || err_o) begin
      n_cmp++;
      if (evq.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_event: got RegWEn=%0b err=%0b AddrD=%0d DataD=%08h, required no event",
                 RegWEn_o, err_o, AddrD_o, DataD_o);
      end else begin
        mon_e = evq.pop_front();
        if (mon_e.is_err) mon_ok = err_o && !RegWEn_o;
        else mon_ok = RegWEn_o && !err_o && (AddrD_o == mon_e.addr) && (DataD_o == mon_e.data);
        if (!mon_ok) begin
          n_bad++;
          $display("FAIL %s: got RegWEn=%0b err=%0b AddrD=%0d DataD=%08h, required err=%0b AddrD=%0d DataD=%08h",
                   mon_e.nm, RegWEn_o, err_o, AddrD_o, DataD_o, mon_e.is_err, mon_e.addr, mon_e.data);
        end
      end
    end
    if (stq.size() != 0) begin
      mon_s = stq.pop_front();
      n_cmp++;
      mon_ok = (ex_ready_o == mon_s.rdy) && (load_busy_o == mon_s.busy) && (load_rd_o == mon_s.lrd);
      if (mon_s.zero)
        mon_ok = mon_ok && !RegWEn_o && !err_o && (AddrD_o == 5'd0) && (DataD_o == 32'd0);
      if (!mon_ok) begin
        n_bad++;
        $display("FAIL %s: got ready=%0b busy=%0b load_rd=%0d RegWEn=%0b err=%0b AddrD=%0d DataD=%08h, required ready=%0b busy=%0b load_rd=%0d zero_outputs=%0b",
                 mon_s.nm, ex_ready_o, load_busy_o, load_rd_o, RegWEn_o, err_o, AddrD_o, DataD_o,
                 mon_s.rdy, mon_s.busy, mon_s.lrd, mon_s.zero);
      end
    end
    if (done) begin
      n_cmp++;
      if (evq.size() != 0) begin
        n_bad++;
        $display("FAIL missing_events: got %0d expected events never seen, required 0", evq.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
    end
  end

  initial begin
    rst_i = 1'b0; ex_valid_i = 1'b0; ex_regwen_i = 1'b0; ex_rd_i = 5'd0;
    ex_wbsel_i = 2'd0; ex_alu_i = 32'd0; ex_pc4_i = 32'd0; ex_funct3_i = 3'd0;
    ex_addr_lo_i = 2'd0; mem_rvalid_i = 1'b0; mem_rdata_i = 32'd0; mem_err_i = 1'b0;
    #1;
    push_st("reset_state", 1'b1, 1'b0, 5'd0, 1'b1);
    tick(); tick();
    rst_i = 1'b1;
    tick();

    // Back-to-back ALU results, PC+4, and the non-writing cases.
    push_st("alu_ready", 1'b1, 1'b0, 5'd0, 1'b0);
    push_wr("alu_rd5", 5'd5, 32'h12345678);
    issue(1'b1, 5'd5, 2'd0, 32'h12345678, 32'd0);
    push_wr("alu_rd6", 5'd6, 32'hDEADBEEF);
    issue(1'b1, 5'd6, 2'd0, 32'hDEADBEEF, 32'd0);
    push_wr("pc4_rd7", 5'd7, 32'h00001004);
    issue(1'b1, 5'd7, 2'd2, 32'h0BADF00D, 32'h00001004);
    issue(1'b1, 5'd0, 2'd0, 32'h0000FFFF, 32'd0);
    issue(1'b1, 5'd9, 2'd3, 32'h11111111, 32'h22222222);
    issue(1'b0, 5'd14, 2'd0, 32'h33333333, 32'd0);
    tick();

    // Legal loads with alignment and extension.
    push_wr("lb_a2", 5'd8, 32'hFFFFFF80);
    do_load(5'd8, 1'b1, 3'b000, 2'd2, 3, 1'b1, 32'h0080FF00, 1'b0);
    push_wr("lbu_a2", 5'd8, 32'h00000080);
    do_load(5'd8, 1'b1, 3'b100, 2'd2, 3, 1'b1, 32'h0080FF00, 1'b0);
    push_wr("lhu_a2", 5'd9, 32'h00000080);
    do_load(5'd9, 1'b1, 3'b101, 2'd2, 2, 1'b1, 32'h0080FF00, 1'b0);
    push_wr("lh_a0", 5'd10, 32'hFFFF8001);
    do_load(5'd10, 1'b1, 3'b001, 2'd0, 1, 1'b1, 32'h12348001, 1'b0);
    push_wr("lb_a3", 5'd11, 32'h0000007F);
    do_load(5'd11, 1'b1, 3'b000, 2'd3, 1, 1'b1, 32'h7F000000, 1'b0);
    push_wr("lw_a0", 5'd12, 32'hCAFEBABE);
    do_load(5'd12, 1'b1, 3'b010, 2'd0, 2, 1'b1, 32'hCAFEBABE, 1'b0);
    do_load(5'd0, 1'b1, 3'b010, 2'd0, 2, 1'b1, 32'hCAFEBABE, 1'b0);
    do_load(5'd13, 1'b0, 3'b010, 2'd0, 1, 1'b1, 32'h01020304, 1'b0);

    // Faulting loads.
    push_err("lh_misaligned");
    do_load(5'd14, 1'b1, 3'b001, 2'd3, 2, 1'b1, 32'h55667788, 1'b0);
    push_err("lw_bus_error");
    do_load(5'd15, 1'b1, 3'b010, 2'd0, 1, 1'b1, 32'h55667788, 1'b1);
    push_err("illegal_funct3");
    do_load(5'd16, 1'b1, 3'b011, 2'd0, 1, 1'b1, 32'h55667788, 1'b0);
    push_err("lw_misaligned");
    do_load(5'd17, 1'b1, 3'b010, 2'd2, 1, 1'b1, 32'h55667788, 1'b0);

    // No response: abandoned after 4 cycles in WAIT_MEM, then a stray rvalid.
    push_err("timeout");
    do_load(5'd18, 1'b1, 3'b000, 2'd0, 4, 1'b0, 32'd0, 1'b0);
    mem_rvalid_i = 1'b1; mem_rdata_i = 32'hAAAA5555;
    tick();
    mem_rvalid_i = 1'b0;
    tick();

    // Asynchronous reset in the middle of a load.
    ex_valid_i = 1'b1; ex_regwen_i = 1'b1; ex_rd_i = 5'd19; ex_wbsel_i = 2'd1;
    ex_funct3_i = 3'b010; ex_addr_lo_i = 2'd0;
    tick();
    ex_valid_i = 1'b0;
    push_st("pre_reset_wait", 1'b0, 1'b1, 5'd19, 1'b0);
    tick();
    rst_i = 1'b0;
    push_st("async_reset", 1'b1, 1'b0, 5'd0, 1'b1);
    tick();
    rst_i = 1'b1;
    mem_rvalid_i = 1'b1; mem_rdata_i = 32'h99999999;
    tick();
    mem_rvalid_i = 1'b0;
    tick();

    push_wr("post_reset_alu", 5'd20, 32'hA5A5A5A5);
    issue(1'b1, 5'd20, 2'd0, 32'hA5A5A5A5, 32'd0);
    tick(); tick();
    done = 1'b1;
    repeat (4) tick();
    $display("FAIL end_of_run: monitor did not finish, required summary");
    $fatal(1);
  end

endmodule
